// File: rtl/count_event_tracker.sv
// Tracks a 4-bit counter stream: classifies each valid step, extends the count across
// wrap-arounds and queues wrap/jump/rollover events for a valid/ready consumer.
module count_event_tracker #(
    parameter int EXT_W = 4,
    parameter int DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic [3:0]         count,
    input  logic               count_valid,
    output logic [EXT_W+3:0]   ext_count,
    output logic               step_up,
    output logic               step_down,
    output logic               step_hold,
    output logic               step_jump,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [1:0]         evt_code,
    output logic [3:0]         evt_count,
    output logic               overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int FW = PW + 1;

    typedef enum logic {EMPTY, TRACK} state_t;

    state_t             state_q;
    logic [3:0]         prev_q;
    logic [EXT_W-1:0]   ext_q;
    logic [EXT_W-1:0]   ext_d;
    logic               step_up_q, step_down_q, step_hold_q, step_jump_q;
    logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
    logic               overflow_q;
    logic [5:0]         mem [DEPTH];

    logic [3:0]         delta;
    logic               classify, is_up, is_down, is_hold, is_jump;
    logic               wrap_up, wrap_down, roll;
    logic               push_first, push_second;
    logic [5:0]         entry_first;
    logic [PW-1:0]      level;
    logic [FW-1:0]      free;
    logic               pop, wr0_en, wr1_en, drop;
    logic [1:0]         push_cnt;
    logic [AW-1:0]      wa0, wa1;

    always_comb begin
        delta       = count - prev_q;
        classify    = count_valid && (state_q == TRACK);
        is_up       = classify && (delta == 4'd1);
        is_down     = classify && (delta == 4'hF);
        is_hold     = classify && (delta == 4'd0);
        is_jump     = classify && !is_up && !is_down && !is_hold;
        wrap_up     = is_up && (prev_q == 4'hF);
        wrap_down   = is_down && (prev_q == 4'h0);
        roll        = (wrap_up && (ext_q == {EXT_W{1'b1}})) ||
                      (wrap_down && (ext_q == {EXT_W{1'b0}}));

        ext_d = ext_q;
        if (wrap_up) begin
            ext_d = ext_q + EXT_W'(1);
        end else if (wrap_down) begin
            ext_d = ext_q - EXT_W'(1);
        end

        push_first  = wrap_up || wrap_down || is_jump;
        push_second = roll;
        entry_first = {2'd2, count};
        if (wrap_up) begin
            entry_first = {2'd0, count};
        end else if (wrap_down) begin
            entry_first = {2'd1, count};
        end

        // Free slots include the slot released by a same-cycle pop.
        level    = wr_ptr_q - rd_ptr_q;
        pop      = evt_valid && evt_ready;
        free     = FW'(DEPTH) - FW'(level) + FW'(pop);
        wr0_en   = push_first && (free != '0) && !clear;
        wr1_en   = push_second && (free >= FW'(2)) && !clear;
        drop     = (push_first && (free == '0)) || (push_second && (free < FW'(2)));
        push_cnt = {1'b0, wr0_en} + {1'b0, wr1_en};
        wa0      = wr_ptr_q[AW-1:0];
        wa1      = wr_ptr_q[AW-1:0] + AW'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            prev_q      <= '0;
            ext_q       <= '0;
            step_up_q   <= 1'b0;
            step_down_q <= 1'b0;
            step_hold_q <= 1'b0;
            step_jump_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
        end else if (clear) begin
            state_q     <= EMPTY;
            prev_q      <= '0;
            ext_q       <= '0;
            step_up_q   <= 1'b0;
            step_down_q <= 1'b0;
            step_hold_q <= 1'b0;
            step_jump_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
        end else begin
            if (count_valid) begin
                prev_q  <= count;
                state_q <= TRACK;
            end
            if (classify) begin
                step_up_q   <= is_up;
                step_down_q <= is_down;
                step_hold_q <= is_hold;
                step_jump_q <= is_jump;
                ext_q       <= ext_d;
            end
            wr_ptr_q <= wr_ptr_q + PW'(push_cnt);
            rd_ptr_q <= rd_ptr_q + PW'(pop);
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset: pointers alone define which entries are live.
    always_ff @(posedge clock) begin
        if (wr0_en) begin
            mem[wa0] <= entry_first;
        end
        if (wr1_en) begin
            mem[wa1] <= {2'd3, count};
        end
    end

    assign ext_count = {ext_q, prev_q};
    assign step_up   = step_up_q;
    assign step_down = step_down_q;
    assign step_hold = step_hold_q;
    assign step_jump = step_jump_q;
    assign evt_valid = (wr_ptr_q != rd_ptr_q);
    assign evt_code  = evt_valid ? mem[rd_ptr_q[AW-1:0]][5:4] : 2'd0;
    assign evt_count = evt_valid ? mem[rd_ptr_q[AW-1:0]][3:0] : 4'd0;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_count_event_tracker.sv
// Bench for count_event_tracker: directed vector table, async-reset sequence and
// randomized traffic checked against a queue-based event model.
module tb_count_event_tracker;

    localparam int EXT_W = 4;
    localparam int DEPTH = 4;
    localparam int EMOD  = 1 << EXT_W;
    localparam logic [3:0] SU = 4'b1000, SD = 4'b0100, SH = 4'b0010, SJ = 4'b0001;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             clear = 1'b0;
    logic [3:0]       count = '0;
    logic             count_valid = 1'b0;
    logic [EXT_W+3:0] ext_count;
    logic             step_up, step_down, step_hold, step_jump;
    logic             evt_valid;
    logic             evt_ready = 1'b0;
    logic [1:0]       evt_code;
    logic [3:0]       evt_count;
    logic             overflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_have;
    int          m_prev, m_ext;
    logic [3:0]  m_step;
    logic [5:0]  m_q[$];
    bit          m_ovf;

    typedef struct {
        bit         clr;
        bit         v;
        logic [3:0] c;
        bit         r;
        logic [7:0] x_ext;
        logic [3:0] x_step;
        bit         x_ev;
        logic [1:0] x_code;
        logic [3:0] x_cnt;
        bit         x_ovf;
    } vec_t;

    vec_t tbl[$];

    count_event_tracker #(.EXT_W(EXT_W), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .clear(clear), .count(count),
        .count_valid(count_valid), .ext_count(ext_count),
        .step_up(step_up), .step_down(step_down), .step_hold(step_hold),
        .step_jump(step_jump), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_code(evt_code), .evt_count(evt_count), .overflow(overflow)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(bit clr, bit v, logic [3:0] c, bit r, logic [7:0] xe,
                                logic [3:0] xs, bit xv, logic [1:0] xc, logic [3:0] xn, bit xo);
        vec_t t;
        t.clr = clr; t.v = v; t.c = c; t.r = r; t.x_ext = xe; t.x_step = xs;
        t.x_ev = xv; t.x_code = xc; t.x_cnt = xn; t.x_ovf = xo;
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_have = 0; m_prev = 0; m_ext = 0; m_step = '0; m_q.delete(); m_ovf = 0;
    endtask

    task automatic model_edge(bit clr, bit v, logic [3:0] c, bit r);
        int codes[$];
        int d, free;
        bit pop;
        if (clr) begin
            model_reset();
            return;
        end
        pop = (m_q.size() > 0) && r;
        if (v) begin
            if (m_have) begin
                d = (int'(c) - m_prev + 16) % 16;
                if (d == 1) begin
                    m_step = SU;
                    if (m_prev == 15) begin
                        codes.push_back(0);
                        if (m_ext == EMOD - 1) codes.push_back(3);
                        m_ext = (m_ext + 1) % EMOD;
                    end
                end else if (d == 15) begin
                    m_step = SD;
                    if (m_prev == 0) begin
                        codes.push_back(1);
                        if (m_ext == 0) codes.push_back(3);
                        m_ext = (m_ext + EMOD - 1) % EMOD;
                    end
                end else if (d == 0) begin
                    m_step = SH;
                end else begin
                    m_step = SJ;
                    codes.push_back(2);
                end
            end
            m_prev = int'(c);
            m_have = 1;
        end
        free = DEPTH - m_q.size() + (pop ? 1 : 0);
        if (pop) void'(m_q.pop_front());
        foreach (codes[i]) begin
            if (free > 0) begin
                m_q.push_back({2'(codes[i]), c});
                free--;
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    task automatic check_model(string tag);
        logic [5:0] head;
        head = (m_q.size() > 0) ? m_q[0] : 6'd0;
        chk({tag, ".ext_count"}, 32'(ext_count), 32'((m_ext * 16 + m_prev) & 8'hFF));
        chk({tag, ".step"}, 32'({step_up, step_down, step_hold, step_jump}), 32'(m_step));
        chk({tag, ".evt_valid"}, 32'(evt_valid), 32'(m_q.size() > 0));
        chk({tag, ".evt_head"}, 32'({evt_code, evt_count}), 32'(head));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    endtask

    // Drive one cycle, let the edge happen, then sample on the falling edge.
    task automatic cycle(bit clr, bit v, logic [3:0] c, bit r, string tag);
        clear = clr; count_valid = v; count = c; evt_ready = r;
        @(posedge clock);
        model_edge(clr, v, c, r);
        @(negedge clock);
        check_model(tag);
        $display("%s clr=%0b v=%0b c=%0h r=%0b -> ext=%02h step=%04b ev=%0b head=%0d/%0h ovf=%0b",
                 tag, clr, v, c, r, ext_count, {step_up, step_down, step_hold, step_jump},
                 evt_valid, evt_code, evt_count, overflow);
    endtask

    initial begin
        // Wrap up
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 14, 0, 8'h0E, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 15, 0, 8'h0F, SU, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 8'h10, SU, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 8'h11, SU, 1, 0, 0, 0));
        // Wrap down with ext rollover
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 15, 0, 8'hFF, SD, 1, 1, 15, 0));
        tbl.push_back(mk(0, 0, 0, 1, 8'hFF, SD, 1, 3, 15, 0));
        tbl.push_back(mk(0, 0, 0, 1, 8'hFF, SD, 0, 0, 0, 0));
        // Hold then jump
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5, 0, 8'h05, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5, 0, 8'h05, SH, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 9, 0, 8'h09, SJ, 1, 2, 9, 0));
        // Fill, overflow, drain in order
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3, 0, 8'h03, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 9, 0, 8'h09, SJ, 1, 2, 9, 0));
        tbl.push_back(mk(0, 1, 3, 0, 8'h03, SJ, 1, 2, 9, 0));
        tbl.push_back(mk(0, 1, 9, 0, 8'h09, SJ, 1, 2, 9, 0));
        tbl.push_back(mk(0, 1, 3, 0, 8'h03, SJ, 1, 2, 9, 0));
        tbl.push_back(mk(0, 1, 9, 0, 8'h09, SJ, 1, 2, 9, 1));
        tbl.push_back(mk(0, 0, 0, 1, 8'h09, SJ, 1, 2, 3, 1));
        tbl.push_back(mk(0, 0, 0, 1, 8'h09, SJ, 1, 2, 9, 1));
        tbl.push_back(mk(0, 0, 0, 1, 8'h09, SJ, 1, 2, 3, 1));
        tbl.push_back(mk(0, 0, 0, 1, 8'h09, SJ, 0, 0, 0, 1));
        // Full FIFO: pop and push in the same cycle
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3, 0, 8'h03, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 9, 0, 8'h09, SJ, 1, 2, 9, 0));
        tbl.push_back(mk(0, 1, 3, 0, 8'h03, SJ, 1, 2, 9, 0));
        tbl.push_back(mk(0, 1, 9, 0, 8'h09, SJ, 1, 2, 9, 0));
        tbl.push_back(mk(0, 1, 3, 0, 8'h03, SJ, 1, 2, 9, 0));
        tbl.push_back(mk(0, 1, 9, 1, 8'h09, SJ, 1, 2, 3, 0));
        tbl.push_back(mk(0, 0, 0, 1, 8'h09, SJ, 1, 2, 9, 0));
        // One free slot with wrap plus rollover: rollover dropped
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3, 0, 8'h03, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 9, 0, 8'h09, SJ, 1, 2, 9, 0));
        tbl.push_back(mk(0, 1, 3, 0, 8'h03, SJ, 1, 2, 9, 0));
        tbl.push_back(mk(0, 1, 0, 0, 8'h00, SJ, 1, 2, 9, 0));
        tbl.push_back(mk(0, 1, 15, 0, 8'hFF, SD, 1, 2, 9, 1));
        tbl.push_back(mk(0, 0, 0, 1, 8'hFF, SD, 1, 2, 3, 1));
        tbl.push_back(mk(0, 0, 0, 1, 8'hFF, SD, 1, 2, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 8'hFF, SD, 1, 1, 15, 1));
        tbl.push_back(mk(0, 0, 0, 1, 8'hFF, SD, 0, 0, 0, 1));
        // Clear from TRACK: first sample afterwards is unclassified
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 7, 0, 8'h07, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8, 0, 8'h08, SU, 0, 0, 0, 0));
    end

    initial begin
        model_reset();
        #12;
        reset = 1'b0;
        @(negedge clock);
        check_model("reset");

        for (int i = 0; i < tbl.size(); i++) begin
            string tg;
            tg = $sformatf("vec%0d", i);
            cycle(tbl[i].clr, tbl[i].v, tbl[i].c, tbl[i].r, tg);
            chk({tg, ".tbl_ext"}, 32'(ext_count), 32'(tbl[i].x_ext));
            chk({tg, ".tbl_step"}, 32'({step_up, step_down, step_hold, step_jump}), 32'(tbl[i].x_step));
            chk({tg, ".tbl_ev"}, 32'(evt_valid), 32'(tbl[i].x_ev));
            chk({tg, ".tbl_head"}, 32'({evt_code, evt_count}), 32'({tbl[i].x_code, tbl[i].x_cnt}));
            chk({tg, ".tbl_ovf"}, 32'(overflow), 32'(tbl[i].x_ovf));
        end

        // Asynchronous reset between edges with a non-empty FIFO and TRACK state
        cycle(0, 1, 3, 0, "ar0");
        cycle(0, 1, 9, 0, "ar1");
        cycle(0, 1, 3, 0, "ar2");
        count_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("async.ext_count", 32'(ext_count), 32'h0);
        chk("async.step", 32'({step_up, step_down, step_hold, step_jump}), 32'h0);
        chk("async.evt_valid", 32'(evt_valid), 32'h0);
        chk("async.evt_head", 32'({evt_code, evt_count}), 32'h0);
        chk("async.overflow", 32'(overflow), 32'h0);
        $display("async reset mid-cycle -> ext=%02h ev=%0b", ext_count, evt_valid);
        #1 reset = 1'b0;
        cycle(0, 1, 6, 0, "ar3");
        cycle(0, 1, 7, 0, "ar4");

        // Randomized traffic biased toward +/-1 steps so wraps and rollovers occur
        for (int i = 0; i < 800; i++) begin
            int sel;
            logic [3:0] c;
            bit v, r, clr;
            sel = $urandom_range(0, 9);
            if (sel < 5)       c = 4'((m_prev + 1) & 15);
            else if (sel < 7)  c = 4'((m_prev + 15) & 15);
            else if (sel == 7) c = 4'(m_prev);
            else               c = 4'($urandom_range(0, 15));
            v   = ($urandom_range(0, 3) != 0);
            r   = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 199) == 0);
            cycle(clr, v, c, r, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
